// File: rtl/trigger_ctrl_pkg.sv
// Shared types and bus widths for the biquad coefficient sequencer.
package trigger_ctrl_pkg;

   localparam int unsigned WB_ADR_W = 22;
   localparam int unsigned WB_DAT_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WRITE,
      RSTBQ,
      DONE
   } state_e;

endpackage

// File: rtl/coeff_stage_fifo.sv
// Synchronous staging FIFO with registered read data, flush, and occupancy count.
module coeff_stage_fifo #(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned WIDTH = 54
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      cnt_q;
   logic [WIDTH-1:0] rd_data_q;
   logic             do_push, do_pop;

   assign full_o    = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o   = (cnt_q == '0);
   assign level_o   = cnt_q;
   assign rd_data_o = rd_data_q;
   assign do_push   = push_i & ~full_o;
   assign do_pop    = pop_i & ~empty_o;

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
   end

   // Flush only resets bookkeeping; the read register keeps its last value.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         rd_data_q <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop) begin
            rd_ptr_q  <= rd_ptr_q + 1'b1;
            rd_data_q <= mem_q[rd_ptr_q];
         end
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/bq_coeff_sequencer.sv
// Stages coefficient writes, replays them over Wishbone on start, then pulses biquad reset.
module bq_coeff_sequencer
   import trigger_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH       = 32,
   parameter int unsigned ACK_TIMEOUT = 255,
   parameter int unsigned RST_CYCLES  = 8
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_ni,
   input  logic                    cfg_valid_i,
   output logic                    cfg_ready_o,
   input  logic [WB_ADR_W-1:0]     cfg_addr_i,
   input  logic [WB_DAT_W-1:0]     cfg_data_i,
   input  logic                    start_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    error_o,
   output logic [$clog2(DEPTH):0]  level_o,
   output logic                    wbm_cyc_o,
   output logic                    wbm_stb_o,
   output logic                    wbm_we_o,
   output logic [WB_ADR_W-1:0]     wbm_adr_o,
   output logic [WB_DAT_W-1:0]     wbm_dat_o,
   output logic [3:0]              wbm_sel_o,
   input  logic                    wbm_ack_i,
   input  logic                    wbm_err_i,
   output logic                    reset_BQ_o
);

   localparam int unsigned CNT_MAX = (ACK_TIMEOUT > RST_CYCLES) ? ACK_TIMEOUT : RST_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   logic [1:0]       rst_sync_q;
   logic             rst_n;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             error_q, error_d;
   logic             push, pop, flush, fifo_full, fifo_empty;

   // Assertion propagates asynchronously; release is held off two clock edges.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) rst_sync_q <= '0;
      else            rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   assign cfg_ready_o = rst_n & ~fifo_full & (state_q == IDLE);
   assign push        = cfg_valid_i & cfg_ready_o;

   coeff_stage_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WB_ADR_W + WB_DAT_W)
   ) u_stage (
      .clk_i     (wb_clk_i),
      .rst_ni    (rst_n),
      .flush_i   (flush),
      .push_i    (push),
      .wr_data_i ({cfg_addr_i, cfg_data_i}),
      .pop_i     (pop),
      .rd_data_o ({wbm_adr_o, wbm_dat_o}),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .level_o   (level_o)
   );

   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         error_q <= error_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      error_d = error_q;
      pop     = 1'b0;
      flush   = 1'b0;
      case (state_q)
         IDLE: begin
            // A push in the same cycle as start joins this sequence.
            if (start_i) begin
               error_d = 1'b0;
               state_d = (!fifo_empty || push) ? FETCH : RSTBQ;
            end
         end
         FETCH: begin
            pop     = 1'b1;
            state_d = WRITE;
         end
         WRITE: begin
            cnt_d = cnt_q + 1'b1;
            if (wbm_err_i || (!wbm_ack_i && cnt_q == CNT_W'(ACK_TIMEOUT - 1))) begin
               error_d = 1'b1;
               flush   = 1'b1;
               state_d = RSTBQ;
            end else if (wbm_ack_i) begin
               state_d = fifo_empty ? RSTBQ : FETCH;
            end
         end
         RSTBQ: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (state_d != state_q) cnt_d = '0;
   end

   assign wbm_cyc_o  = (state_q == WRITE);
   assign wbm_stb_o  = (state_q == WRITE);
   assign wbm_we_o   = (state_q == WRITE);
   assign wbm_sel_o  = 4'hF;
   assign reset_BQ_o = (state_q == RSTBQ);
   assign done_o     = (state_q == DONE);
   assign busy_o     = (state_q != IDLE);
   assign error_o    = error_q;

endmodule

// File: tb/tb_bq_coeff_sequencer.sv
// Directed self-checking bench for bq_coeff_sequencer.
module tb_bq_coeff_sequencer;

   localparam int unsigned DEPTH = 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_valid = 1'b0, cfg_ready;
   logic [21:0] cfg_addr = '0;
   logic [31:0] cfg_data = '0;
   logic        start = 1'b0, busy, done, error;
   logic [5:0]  level;
   logic        cyc, stb, we;
   logic [21:0] adr;
   logic [31:0] dat;
   logic [3:0]  sel;
   logic        ack = 1'b0, err = 1'b0, rst_bq;

   int unsigned n_assert = 0;
   int unsigned n_fail = 0;
   int unsigned cyc_cnt = 0;

   always #5 clk = ~clk;

   bq_coeff_sequencer #(.DEPTH(DEPTH), .ACK_TIMEOUT(255), .RST_CYCLES(8)) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n),
      .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
      .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data),
      .start_i(start), .busy_o(busy), .done_o(done), .error_o(error),
      .level_o(level),
      .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we),
      .wbm_adr_o(adr), .wbm_dat_o(dat), .wbm_sel_o(sel),
      .wbm_ack_i(ack), .wbm_err_i(err), .reset_BQ_o(rst_bq)
   );

   always @(negedge clk) if (cyc) cyc_cnt++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic push(input logic [21:0] a, input logic [31:0] d);
      chk("push_ready", cfg_ready, 1);
      cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic bus_write(input logic [21:0] a, input logic [31:0] d);
      int n = 0;
      while (!cyc && n < 8) begin tick(); n++; end
      chk("wr_cyc", cyc, 1);
      chk("wr_stb_we", {stb, we, sel}, 6'b11_1111);
      chk("wr_adr", adr, a);
      chk("wr_dat", dat, d);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("wr_cyc_drop", cyc, 0);
   endtask

   task automatic rst_pulse();
      int n = 0;
      while (rst_bq && n < 40) begin n++; tick(); end
      chk("rstbq_len", n, 8);
      chk("done_pulse", done, 1);
      chk("done_no_cyc", cyc, 0);
      tick();
      chk("done_clear", done, 0);
      chk("idle_busy", busy, 0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int m;
      int unsigned c0;

      // Reset state
      repeat (3) tick();
      chk("rst_cyc", {cyc, stb, we}, 0);
      chk("rst_busy_done", {busy, done, error, rst_bq}, 0);
      chk("rst_level", level, 0);
      chk("rst_adr_dat", {adr, dat}, 0);
      rst_n = 1'b1;
      repeat (3) tick();
      chk("post_rst_ready", cfg_ready, 1);

      // Three writes, one-cycle ack latency
      push(22'h10, 32'hA);
      push(22'h11, 32'hB);
      push(22'h12, 32'hC);
      chk("level3", level, 3);
      do_start();
      chk("fetch_no_cyc", cyc, 0);
      chk("fetch_busy", busy, 1);
      chk("fetch_not_ready", cfg_ready, 0);
      tick();
      chk("cyc_two_after", cyc, 1);
      bus_write(22'h10, 32'hA);
      bus_write(22'h11, 32'hB);
      bus_write(22'h12, 32'hC);
      chk("seq1_rstbq", rst_bq, 1);
      rst_pulse();
      chk("seq1_err", error, 0);
      chk("seq1_level", level, 0);

      // Start with empty FIFO
      c0 = cyc_cnt;
      do_start();
      chk("empty_rstbq", rst_bq, 1);
      rst_pulse();
      chk("empty_no_cyc", cyc_cnt - c0, 0);

      // Fill to DEPTH, overflow held off, full drain (pointers wrap)
      for (int i = 0; i < 32; i++) push(22'h100 + 22'(i), 32'hC0DE_0000 + 32'(i));
      chk("full_level", level, 32);
      chk("full_ready", cfg_ready, 0);
      cfg_valid = 1'b1; cfg_addr = 22'h3FFFFF; cfg_data = 32'hDEAD_BEEF;
      tick(); tick();
      cfg_valid = 1'b0;
      chk("full_hold_level", level, 32);
      do_start();
      for (int i = 0; i < 32; i++) bus_write(22'h100 + 22'(i), 32'hC0DE_0000 + 32'(i));
      rst_pulse();
      chk("drain_level", level, 0);
      chk("drain_err", error, 0);

      // Target never acks write 2 of 4
      for (int i = 0; i < 4; i++) push(22'h20 + 22'(i), 32'h50 + 32'(i));
      do_start();
      bus_write(22'h20, 32'h50);
      m = 0;
      while (!cyc && m < 8) begin tick(); m++; end
      chk("to_adr", adr, 22'h21);
      m = 0;
      while (cyc && m < 400) begin m++; tick(); end
      chk("to_cyc_len", m, 255);
      chk("to_err", error, 1);
      chk("to_level", level, 0);
      chk("to_rstbq", rst_bq, 1);
      rst_pulse();
      chk("to_err_sticky", error, 1);

      // err together with ack on write 1
      push(22'h30, 32'h5);
      push(22'h31, 32'h6);
      do_start();
      chk("start_clears_err", error, 0);
      m = 0;
      while (!cyc && m < 8) begin tick(); m++; end
      chk("err_adr", adr, 22'h30);
      ack = 1'b1; err = 1'b1;
      tick();
      ack = 1'b0; err = 1'b0;
      chk("err_cyc_drop", cyc, 0);
      chk("err_flag", error, 1);
      chk("err_level", level, 0);
      chk("err_rstbq", rst_bq, 1);
      rst_pulse();

      // Push and start in the same cycle
      cfg_valid = 1'b1; cfg_addr = 22'h55; cfg_data = 32'h1234_5678; start = 1'b1;
      tick();
      cfg_valid = 1'b0; start = 1'b0;
      chk("same_cyc_busy", busy, 1);
      bus_write(22'h55, 32'h1234_5678);
      rst_pulse();
      chk("same_cyc_err", error, 0);

      // Reset asserted mid-WRITE, late ack after release
      push(22'h40, 32'h7);
      push(22'h41, 32'h8);
      do_start();
      m = 0;
      while (!cyc && m < 8) begin tick(); m++; end
      chk("mid_cyc", cyc, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_bus", {cyc, stb, we, rst_bq}, 0);
      chk("mid_rst_state", {busy, done, error}, 0);
      chk("mid_rst_level", level, 0);
      tick();
      ack = 1'b1;
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      ack = 1'b0;
      tick();
      chk("late_ack_idle", {busy, cyc}, 0);
      chk("late_ack_ready", cfg_ready, 1);
      chk("late_ack_level", level, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
